fetch_unit: RTL and testbench

- Instruction fetch stage for the 16-bit processor. It sits directly upstream of the instruction decoder.
- Maintains a word-addressed PC and fetches one instruction at a time from instruction memory.
- Presents each instruction to the decoder over a valid/ready handshake.
- Applies branch redirects resolved by the execute stage. Stops permanently on a consumed HALT instruction.

---
 rtl/proc_pkg.sv | 39 +++
 rtl/branch_target.sv | 24 ++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor front end: branch selects,
// fetch state encoding and the branch-condition helper.
package proc_pkg;

  localparam int unsigned INST_W = 16;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned BS_W   = 3;

  localparam logic [BS_W-1:0] BS_EQ   = 3'b000;
  localparam logic [BS_W-1:0] BS_NE   = 3'b001;
  localparam logic [BS_W-1:0] BS_GEZ  = 3'b010;
  localparam logic [BS_W-1:0] BS_LTZ  = 3'b011;
  localparam logic [BS_W-1:0] BS_NONE = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_HALT = 3'd4
  } fetch_state_e;

  // Branch condition from the select code and ALU flags; unknown codes never take.
  function automatic logic bs_taken(input logic [BS_W-1:0] bs,
                                    input logic            zero,
                                    input logic            neg);
    logic t;
    t = 1'b0;
    case (bs)
      BS_EQ:   t = zero;
      BS_NE:   t = ~zero;
      BS_GEZ:  t = ~neg;
      BS_LTZ:  t = neg;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_target.sv
// Combinational branch resolution: taken flag and PC-relative target.
module branch_target
  import proc_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic              br_valid_i,
  input  logic [BS_W-1:0]   br_bs_i,
  input  logic [OFF_W-1:0]  br_off_i,
  input  logic [PC_W-1:0]   br_pc_i,
  input  logic              alu_zero_i,
  input  logic              alu_neg_i,
  output logic              taken_c,
  output logic [PC_W-1:0]   target_c
);

  logic [PC_W-1:0] off_ext;

  // Offset is relative to the instruction after the branch.
  assign off_ext  = PC_W'($signed(br_off_i));
  assign target_c = br_pc_i + PC_W'(1) + off_ext;
  assign taken_c  = br_valid_i & bs_taken(br_bs_i, alu_zero_i, alu_neg_i);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, valid/ready hand-off
// to the decoder, branch redirect with squash of in-flight data, sticky HALT.
module fetch_unit
  import proc_pkg::*;
#(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              halt_in,
  input  logic              br_valid,
  input  logic [BS_W-1:0]   br_bs,
  input  logic [OFF_W-1:0]  br_off,
  input  logic [PC_W-1:0]   br_pc,
  input  logic              alu_zero,
  input  logic              alu_neg,
  output logic              halted
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  fetch_state_e      state_q,   state_d;
  logic [PC_W-1:0]   pc_q,      pc_d;
  logic              squash_q,  squash_d;
  logic [INST_W-1:0] inst_q,    inst_d;
  logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
  logic              req_q,     req_d;
  logic [PC_W-1:0]   addr_q,    addr_d;
  logic              valid_q,   valid_d;
  logic              halted_q,  halted_d;

  logic              taken;
  logic [PC_W-1:0]   target;

  branch_target #(
    .PC_W (PC_W)
  ) u_branch_target (
    .br_valid_i (br_valid),
    .br_bs_i    (br_bs),
    .br_off_i   (br_off),
    .br_pc_i    (br_pc),
    .alu_zero_i (alu_zero),
    .alu_neg_i  (alu_neg),
    .taken_c    (taken),
    .target_c   (target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RST_PC;
      squash_q  <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      req_q     <= 1'b0;
      addr_q    <= RST_PC;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      squash_q  <= squash_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
    end
  end

  // Next-state logic; a taken redirect outranks everything except HALT.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    squash_d  = squash_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (taken) pc_d = target;
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        if (taken) begin
          pc_d     = target;
          squash_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (taken) begin
          pc_d = target;
          if (imem_rvalid) begin
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            squash_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            pc_d      = pc_q + PC_W'(1);
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (taken) begin
          pc_d    = target;
          state_d = ST_REQ;
        end else if (inst_ready) begin
          state_d = halt_in ? ST_HALT : ST_REQ;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the upcoming state so they align with it.
  always_comb begin
    req_d    = (state_d == ST_REQ);
    addr_d   = (state_d == ST_REQ) ? pc_d : addr_q;
    valid_d  = (state_d == ST_HOLD);
    halted_d = (state_d == ST_HALT);
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = valid_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory responder.
module tb_fetch_unit;

  localparam int unsigned PC_W = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rvalid;
  logic [15:0]     imem_rdata;
  logic [15:0]     inst;
  logic [PC_W-1:0] inst_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic            halt_in;
  logic            br_valid;
  logic [2:0]      br_bs;
  logic [5:0]      br_off;
  logic [PC_W-1:0] br_pc;
  logic            alu_zero;
  logic            alu_neg;
  logic            halted;

  int total = 0;
  int bad   = 0;

  int          mem_lat;
  bit          mem_busy;
  int          mem_cnt;
  logic [15:0] mem_addr;

  fetch_unit #(.PC_W(PC_W), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .halt_in     (halt_in),
    .br_valid    (br_valid),
    .br_bs       (br_bs),
    .br_off      (br_off),
    .br_pc       (br_pc),
    .alu_zero    (alu_zero),
    .alu_neg     (alu_neg),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'd3) ? 16'hF0D1 : 16'h5000 + a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then play the memory: answer mem_lat cycles after a request.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (mem_busy) begin
      if (mem_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_busy    = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    if (imem_req === 1'b1) begin
      mem_busy = 1'b1;
      mem_cnt  = mem_lat;
      mem_addr = imem_addr;
    end
  endtask

  task automatic chk_req(input string tag, input logic [15:0] addr);
    chk({tag, "_req"},   32'(imem_req),   32'd1);
    chk({tag, "_addr"},  32'(imem_addr),  32'(addr));
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"},   32'(imem_req),   32'd0);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
  endtask

  task automatic chk_hold(input string tag, input logic [15:0] word, input logic [15:0] pc);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
    chk({tag, "_inst"},  32'(inst),       32'(word));
    chk({tag, "_pc"},    32'(inst_pc),    32'(pc));
    chk({tag, "_req"},   32'(imem_req),   32'd0);
  endtask

  initial begin
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b1; halt_in = 1'b0; br_valid = 1'b0; br_bs = 3'b100;
    br_off = '0; br_pc = '0; alu_zero = 1'b0; alu_neg = 1'b0;
    mem_lat = 1; mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0;

    repeat (2) tick();
    chk("rst_req",    32'(imem_req),   32'd0);
    chk("rst_addr",   32'(imem_addr),  32'd0);
    chk("rst_inst",   32'(inst),       32'd0);
    chk("rst_pc",     32'(inst_pc),    32'd0);
    chk("rst_valid",  32'(inst_valid), 32'd0);
    chk("rst_halted", 32'(halted),     32'd0);
    rst_n = 1'b1;

    // Sequential fetch, latency 1, decoder always ready
    tick(); chk_req("boot0", 16'd0);
    tick(); chk_quiet("boot0_wait");
    tick(); chk_hold("boot0_hold", 16'h5000, 16'd0);
    tick(); chk_req("boot1", 16'd1);
    tick(); chk_quiet("boot1_wait");
    tick(); chk_hold("boot1_hold", 16'h5001, 16'd1);
    tick(); chk_req("boot2", 16'd2);
    tick();
    tick(); chk_hold("boot2_hold", 16'h5002, 16'd2);
    tick(); chk_req("boot3", 16'd3);
    tick();
    tick(); chk_hold("bp_first", 16'hF0D1, 16'd3);

    // Backpressure
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_hold("bp_stall", 16'hF0D1, 16'd3);
    end
    inst_ready = 1'b1;
    tick(); chk_req("bp_release", 16'd4);
    tick();
    tick(); chk_hold("pre_br_hold", 16'h5004, 16'd4);

    // Taken BEQ from HOLD: 10 + 1 - 4 = 7
    inst_ready = 1'b0; br_valid = 1'b1; br_bs = 3'b000; alu_zero = 1'b1; alu_neg = 1'b0;
    br_pc = 16'd10; br_off = 6'b111100;
    tick(); chk_req("br_taken", 16'd7);
    br_valid = 1'b0; inst_ready = 1'b1;
    tick();
    tick(); chk_hold("br_target_hold", 16'h5007, 16'd7);

    // Not-taken branches leave the held instruction alone
    inst_ready = 1'b0; br_valid = 1'b1; br_bs = 3'b001; alu_zero = 1'b1;
    tick(); chk_hold("nt_ne", 16'h5007, 16'd7);
    br_bs = 3'b100; alu_neg = 1'b1;
    tick(); chk_hold("nt_none", 16'h5007, 16'd7);
    br_valid = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;

    // Squash: redirect to 15 + 1 + 4 = 20 while waiting, latency 3
    mem_lat = 3; inst_ready = 1'b1;
    tick(); chk_req("sq_req", 16'd8);
    tick(); chk_quiet("sq_wait0");
    br_valid = 1'b1; br_bs = 3'b011; alu_neg = 1'b1; br_pc = 16'd15; br_off = 6'd4;
    tick(); chk_quiet("sq_wait1");
    br_valid = 1'b0; alu_neg = 1'b0;
    tick(); chk_quiet("sq_stale");
    tick(); chk_req("sq_target", 16'd20);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_quiet("sq_refetch");
    end
    tick(); chk_hold("sq_data", 16'h5014, 16'd20);

    // Halt on handshake; later taken branch ignored
    halt_in = 1'b1;
    tick();
    chk("halt_flag",  32'(halted),     32'd1);
    chk_quiet("halt_now");
    halt_in = 1'b0; br_valid = 1'b1; br_bs = 3'b000; alu_zero = 1'b1; br_pc = '0; br_off = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_sticky", 32'(halted), 32'd1);
      chk_quiet("halt_quiet");
    end
    br_valid = 1'b0; alu_zero = 1'b0;

    // Restart, then async reset in the middle of a WAIT
    rst_n = 1'b0;
    #1 chk("rst2_halted", 32'(halted), 32'd0);
    mem_busy = 1'b0; mem_lat = 1;
    tick(); rst_n = 1'b1;
    tick(); chk_req("rst2_boot", 16'd0);
    tick();
    tick(); chk_hold("rst2_hold", 16'h5000, 16'd0);
    mem_lat = 3;
    tick(); chk_req("rst2_req1", 16'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",    32'(imem_req),   32'd0);
    chk("arst_addr",   32'(imem_addr),  32'd0);
    chk("arst_inst",   32'(inst),       32'd0);
    chk("arst_pc",     32'(inst_pc),    32'd0);
    chk("arst_valid",  32'(inst_valid), 32'd0);
    chk("arst_halted", 32'(halted),     32'd0);
    tick(); rst_n = 1'b1;
    tick(); chk_req("arst_restart", 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_quiet("arst_wait");
    end
    tick(); chk_hold("arst_hold", 16'h5000, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
